// File: rtl/cva6_regfile_banked.sv
// cva6_regfile_banked
// Flip-flop register file with NUM_CTX independent banks (hardware thread
// contexts). Reads are combinational with optional same-cycle write bypass;
// writes land on the rising clock edge. A small clear engine zeroes one
// whole context, CLR_PER_CYCLE words per cycle, while the other contexts
// keep operating normally.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   raddr_i, rctx_i    per read port: word address and context
//   rdata_o            per read port: read data (combinational)
//   waddr_i, wctx_i    per write port: word address and context
//   wdata_i, we_i      per write port: write data and enable
//   clr_req_i          request clearing of context clr_ctx_i (taken in IDLE)
//   clr_ctx_i          context to clear
//   clr_busy_o         clear engine active (CLEAR or DONE)
//   clr_done_o         single-cycle pulse in the DONE state
module cva6_regfile_banked #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned NUM_WORDS      = 32,
  parameter int unsigned NUM_CTX        = 2,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter bit          ZERO_REG_ZERO  = 1'b1,
  parameter bit          BYPASS         = 1'b1,
  parameter int unsigned CLR_PER_CYCLE  = 4,
  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned CW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NR_READ_PORTS-1:0][AW-1:0]           raddr_i,
  input  logic [NR_READ_PORTS-1:0][CW-1:0]           rctx_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
  input  logic [NR_WRITE_PORTS-1:0][AW-1:0]          waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][CW-1:0]          wctx_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                  we_i,
  input  logic                                       clr_req_i,
  input  logic [CW-1:0]                              clr_ctx_i,
  output logic                                       clr_busy_o,
  output logic                                       clr_done_o
);

  // Storage is padded to full power-of-two index ranges so that any address
  // or context value indexes safely; padded entries are never written and
  // therefore stay zero, which is also the required out-of-range read value.
  localparam int unsigned WORD_DEPTH = 1 << AW;
  localparam int unsigned CTX_DEPTH  = 1 << CW;

  localparam logic [AW-1:0] CLR_STEP = AW'(CLR_PER_CYCLE);
  localparam logic [AW-1:0] LAST_PTR = AW'(NUM_WORDS - CLR_PER_CYCLE);

  // Elaboration-time lookup of which word indices really exist.
  function automatic logic [WORD_DEPTH-1:0] word_ok_mask();
    logic [WORD_DEPTH-1:0] m;
    for (int unsigned i = 0; i < WORD_DEPTH; i++) begin
      m[i] = (i < NUM_WORDS);
    end
    return m;
  endfunction

  // Elaboration-time lookup of which context indices really exist.
  function automatic logic [CTX_DEPTH-1:0] ctx_ok_mask();
    logic [CTX_DEPTH-1:0] m;
    for (int unsigned i = 0; i < CTX_DEPTH; i++) begin
      m[i] = (i < NUM_CTX);
    end
    return m;
  endfunction

  localparam logic [WORD_DEPTH-1:0] WORD_OK = word_ok_mask();
  localparam logic [CTX_DEPTH-1:0]  CTX_OK  = ctx_ok_mask();

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  clr_state_e                state_q, state_d;
  logic [CW-1:0]             clr_ctx_q, clr_ctx_d;
  logic [AW-1:0]             clr_ptr_q, clr_ptr_d;
  logic                      busy_q, done_q;
  logic [NR_WRITE_PORTS-1:0] wr_ok;

  logic [DATA_WIDTH-1:0] mem_q [CTX_DEPTH][WORD_DEPTH];

  assign clr_busy_o = busy_q;
  assign clr_done_o = done_q;

  // Qualify each write port: drop out-of-range targets, register 0 when it is
  // hardwired, and anything aimed at the context being cleared.
  always_comb begin
    wr_ok = '0;
    for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
      wr_ok[j] = we_i[j]
               & WORD_OK[waddr_i[j]]
               & CTX_OK[wctx_i[j]]
               & ~(ZERO_REG_ZERO && (waddr_i[j] == '0))
               & ~(busy_q && (wctx_i[j] == clr_ctx_q));
    end
  end

  // Register array: port writes in ascending index order so the highest port
  // wins; the clear engine owns its context exclusively, so no overlap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned c = 0; c < CTX_DEPTH; c++) begin
        for (int unsigned w = 0; w < WORD_DEPTH; w++) begin
          mem_q[c][w] <= '0;
        end
      end
    end else begin
      for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
        if (wr_ok[j]) begin
          mem_q[wctx_i[j]][waddr_i[j]] <= wdata_i[j];
        end
      end
      if (state_q == CLEAR) begin
        for (int unsigned k = 0; k < CLR_PER_CYCLE; k++) begin
          mem_q[clr_ctx_q][clr_ptr_q + AW'(k)] <= '0;
        end
      end
    end
  end

  // Combinational read with optional forwarding of same-cycle write data.
  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < NR_READ_PORTS; i++) begin
      if (WORD_OK[raddr_i[i]] && CTX_OK[rctx_i[i]]
          && !(ZERO_REG_ZERO && (raddr_i[i] == '0))
          && !(busy_q && (rctx_i[i] == clr_ctx_q))) begin
        rdata_o[i] = mem_q[rctx_i[i]][raddr_i[i]];
        // wr_ok already excludes every dropped write, so a hit here is
        // exactly a write that will land at this location.
        for (int unsigned j = 0; j < NR_WRITE_PORTS; j++) begin
          rdata_o[i] = (BYPASS && wr_ok[j] && (wctx_i[j] == rctx_i[i])
                        && (waddr_i[j] == raddr_i[i])) ? wdata_i[j] : rdata_o[i];
        end
      end else begin
        rdata_o[i] = '0;
      end
    end
  end

  // Clear engine next-state logic.
  always_comb begin
    state_d   = state_q;
    clr_ctx_d = clr_ctx_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i && CTX_OK[clr_ctx_i]) begin
          state_d   = CLEAR;
          clr_ctx_d = clr_ctx_i;
          clr_ptr_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + CLR_STEP;
        if (clr_ptr_q == LAST_PTR) begin
          state_d = DONE;
        end else begin
          state_d = CLEAR;
        end
      end
      DONE: begin
        state_d   = IDLE;
        clr_ptr_d = '0;
      end
      default: begin
        state_d   = IDLE;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Clear engine state plus registered status outputs derived from next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      clr_ctx_q <= '0;
      clr_ptr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ctx_q <= clr_ctx_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_cva6_regfile_banked.sv
module tb_cva6_regfile_banked;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 1;
  localparam int NR = 2;
  localparam int NW = 2;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic [NR-1:0][AW-1:0]       raddr_i;
  logic [NR-1:0][CW-1:0]       rctx_i;
  logic [NR-1:0][DW-1:0]       rdata_o;
  logic [NW-1:0][AW-1:0]       waddr_i;
  logic [NW-1:0][CW-1:0]       wctx_i;
  logic [NW-1:0][DW-1:0]       wdata_i;
  logic [NW-1:0]               we_i;
  logic                        clr_req_i;
  logic [CW-1:0]               clr_ctx_i;
  logic                        clr_busy_o;
  logic                        clr_done_o;

  always #5 clk_i = ~clk_i;

  cva6_regfile_banked #(
    .DATA_WIDTH(64), .NUM_WORDS(32), .NUM_CTX(2),
    .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
    .ZERO_REG_ZERO(1'b1), .BYPASS(1'b1), .CLR_PER_CYCLE(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .raddr_i(raddr_i), .rctx_i(rctx_i), .rdata_o(rdata_o),
    .waddr_i(waddr_i), .wctx_i(wctx_i), .wdata_i(wdata_i), .we_i(we_i),
    .clr_req_i(clr_req_i), .clr_ctx_i(clr_ctx_i),
    .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o)
  );

  // kind 0: rdata_o[idx]; kind 1: clr_busy_o; kind 2: clr_done_o
  typedef struct {
    int          kind;
    int          idx;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model [2][32];

  task automatic push(input int kind, input int idx, input logic [63:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic rd(input int p, input int ctx, input int addr, input logic [63:0] exp, input string name);
    raddr_i[p] = addr[AW-1:0];
    rctx_i[p]  = ctx[CW-1:0];
    push(0, p, exp, name);
  endtask

  task automatic wr(input int p, input int ctx, input int addr, input logic [63:0] d);
    waddr_i[p] = addr[AW-1:0];
    wctx_i[p]  = ctx[CW-1:0];
    wdata_i[p] = d;
    we_i[p]    = 1'b1;
  endtask

  task automatic status(input bit busy, input bit done, input string name);
    push(1, 0, {63'd0, busy}, {name, "_busy"});
    push(2, 0, {63'd0, done}, {name, "_done"});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    we_i      = '0;
    clr_req_i = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the DUT mid-cycle.
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(negedge clk_i);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          0:       act = rdata_o[e.idx];
          1:       act = {63'd0, clr_busy_o};
          default: act = {63'd0, clr_done_o};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni    = 1'b0;
    raddr_i   = '0;
    rctx_i    = '0;
    waddr_i   = '0;
    wctx_i    = '0;
    wdata_i   = '0;
    we_i      = '0;
    clr_req_i = 1'b0;
    clr_ctx_i = '0;
    for (int c = 0; c < 2; c++) for (int a = 0; a < 32; a++) model[c][a] = 64'd0;

    repeat (2) @(posedge clk_i);
    #1;
    status(1'b0, 1'b0, "in_reset");
    rd(0, 1, 4, 64'd0, "in_reset_rd");
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    tick();

    // Reset contents of both contexts.
    for (int a = 0; a < 32; a++) begin
      rd(0, 0, a, 64'd0, "rst_ctx0");
      rd(1, 1, a, 64'd0, "rst_ctx1");
      if (a == 0) status(1'b0, 1'b0, "post_reset");
      tick();
    end

    // Basic write then read; contexts isolated.
    wr(0, 1, 5, 64'hA5A5);
    tick();
    rd(0, 1, 5, 64'hA5A5, "wr_ctx1");
    rd(1, 0, 5, 64'd0, "ctx_isolation");
    tick();

    // Two ports to the same word: highest port wins, forwarded same cycle.
    wr(0, 0, 3, 64'h11);
    wr(1, 0, 3, 64'h22);
    rd(0, 0, 3, 64'h22, "bypass_prio");
    rd(1, 1, 3, 64'd0, "bypass_ctx_miss");
    tick();
    rd(0, 0, 3, 64'h22, "prio_stored");
    tick();

    // Register 0 hardwired to zero, even with bypass.
    wr(0, 0, 0, 64'hFF);
    wr(1, 0, 7, 64'h77);
    rd(0, 0, 0, 64'd0, "zero_reg_bypass");
    rd(1, 0, 7, 64'h77, "bypass_port1");
    tick();
    rd(0, 0, 0, 64'd0, "zero_reg_stored");
    tick();

    // Fill both contexts.
    for (int a = 1; a < 32; a++) begin
      wr(0, 0, a, 64'h1000 + 64'(a));
      wr(1, 1, a, 64'h2000 + 64'(a));
      model[0][a] = 64'h1000 + 64'(a);
      model[1][a] = 64'h2000 + 64'(a);
      tick();
    end
    rd(0, 0, 31, 64'h101F, "fill_ctx0");
    rd(1, 1, 17, 64'h2011, "fill_ctx1");
    tick();

    // Clear context 1: 8 CLEAR cycles then DONE.
    clr_req_i = 1'b1;
    clr_ctx_i = 1'b1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      status(c <= 9, c == 9, "clr_seq");
      if (c == 1) begin
        rd(0, 1, 20, 64'd0, "clr_read_mask");
        wr(1, 0, 9, 64'hBEEF);
        model[0][9] = 64'hBEEF;
        rd(1, 0, 9, 64'hBEEF, "other_ctx_bypass");
      end
      if (c == 2 || c == 9) begin
        clr_req_i = 1'b1;
        clr_ctx_i = 1'b0;
      end
      if (c == 5) begin
        wr(0, 1, 1, 64'hDEAD);
        rd(0, 1, 1, 64'd0, "clr_bypass_mask");
        rd(1, 0, 12, 64'h100C, "other_ctx_read");
      end
      if (c == 9) wr(0, 1, 2, 64'hCAFE);
      tick();
    end

    // Context 1 fully zero, context 0 untouched except the write that landed.
    for (int a = 0; a < 32; a++) begin
      rd(0, 0, a, (a == 0) ? 64'd0 : model[0][a], "post_clr_ctx0");
      rd(1, 1, a, 64'd0, "post_clr_ctx1");
      tick();
    end

    // Reset during the third CLEAR cycle.
    clr_req_i = 1'b1;
    clr_ctx_i = 1'b0;
    tick();
    status(1'b1, 1'b0, "clr2_c1");
    tick();
    status(1'b1, 1'b0, "clr2_c2");
    tick();
    rst_ni = 1'b0;
    #1;
    status(1'b0, 1'b0, "mid_clr_reset");
    rd(0, 0, 31, 64'd0, "mid_clr_reset_rd");
    rd(1, 0, 9, 64'd0, "mid_clr_reset_rd2");
    tick();
    rst_ni = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd(0, 0, a, 64'd0, "after_rst_ctx0");
      rd(1, 1, a, 64'd0, "after_rst_ctx1");
      status(1'b0, 1'b0, "after_rst");
      tick();
    end

    tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cva6_regfile_banked.md
Name: cva6_regfile_banked

Overview:
Flip-flop integer/FP register file for CVA6 with NUM_CTX independent register banks (hardware thread contexts). It has configurable depth, width and read/write port counts, optional same-cycle write-to-read bypass, and a multi-cycle hardware context-clear engine. It sits between issue (read operands) and commit (write-back), replacing the single-bank file when multi-context builds are enabled.

Parameters:
CVA6Cfg, config_pkg::cva6_cfg_empty, core configuration; unused beyond port counts derived below
DATA_WIDTH, 64, register width in bits
NUM_WORDS, 32, registers per context; must be >=2
NUM_CTX, 2, number of banks/contexts; must be >=1
NR_READ_PORTS, 2, read port count
NR_WRITE_PORTS, 2, write port count (normally CVA6Cfg.NrCommitPorts)
ZERO_REG_ZERO, 1, register 0 of each context reads as 0 and ignores writes
BYPASS, 1, same-cycle write data forwarded to matching reads
CLR_PER_CYCLE, 4, words zeroed per cycle by clear engine; must divide NUM_WORDS
Derived: AW = $clog2(NUM_WORDS); CW = max(1,$clog2(NUM_CTX)).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
raddr_i  in  NR_READ_PORTS x AW  read addresses
rctx_i  in  NR_READ_PORTS x CW  read contexts
rdata_o  out  NR_READ_PORTS x DATA_WIDTH  read data (combinational)
waddr_i  in  NR_WRITE_PORTS x AW  write addresses
wctx_i  in  NR_WRITE_PORTS x CW  write contexts
wdata_i  in  NR_WRITE_PORTS x DATA_WIDTH  write data
we_i  in  NR_WRITE_PORTS  write enables
clr_req_i  in  1  request zeroing of context clr_ctx_i (sampled in IDLE)
clr_ctx_i  in  CW  context to clear
clr_busy_o  out  1  clear engine active
clr_done_o  out  1  one-cycle pulse at clear completion

Behaviour:
- Reset (async, rst_ni low): all words of all contexts = 0; FSM = IDLE; clr_busy_o = 0; clr_done_o = 0; clear pointer = 0.
- Writes: take effect at the rising edge when we_i[j]=1. Address >= NUM_WORDS or context >= NUM_CTX: write dropped. Multiple ports to the same ctx/addr in one cycle: highest port index wins.
- ZERO_REG_ZERO=1: writes to addr 0 dropped; reads of addr 0 return 0 regardless of BYPASS.
- Reads: combinational, zero latency. Out-of-range address/context returns 0.
- BYPASS=1: if any port j writes (we_i[j]) the same ctx/addr as read port i in the same cycle, rdata_o[i] = wdata_i of the highest such j. BYPASS=0: returns the stored (pre-edge) value.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req_i=1 -> latch clr_ctx_i into clr_ctx_q, pointer=0, go to CLEAR. clr_ctx_i >= NUM_CTX: request ignored, stay IDLE.
  - CLEAR: each cycle zero words [ptr, ptr+CLR_PER_CYCLE-1] of clr_ctx_q; ptr += CLR_PER_CYCLE. When the last group is written (ptr = NUM_WORDS-CLR_PER_CYCLE), go to DONE. Duration = NUM_WORDS/CLR_PER_CYCLE cycles.
  - DONE: clr_done_o=1 for exactly this cycle; go to IDLE. A new clr_req_i is accepted only from the following IDLE cycle.
  - clr_busy_o = 1 in CLEAR and DONE.
- While clr_busy_o=1:
  - All writes to clr_ctx_q are dropped.
  - Reads of clr_ctx_q return 0, including bypass.
  - clr_req_i is ignored (not queued).
  - Other contexts operate normally.
- Reset asserted mid-clear: FSM returns to IDLE immediately; all storage is zero; no clr_done_o pulse.

Test Plan:
- Reset, then read ctx0/ctx1 addrs 0..NUM_WORDS-1 -> all 0; clr_busy_o=0, clr_done_o=0.
- Port0 writes ctx1 addr5 = 0xA5A5, next cycle read ctx1 addr5 -> 0xA5A5; ctx0 addr5 -> 0.
- Same cycle: port0 and port1 both write ctx0 addr3 with 0x11 and 0x22, read port0 on ctx0 addr3 -> 0x22 (BYPASS=1); after edge -> 0x22. With BYPASS=0, the same-cycle read returns 0.
- Write ctx0 addr0 = 0xFF with ZERO_REG_ZERO=1 -> read addr0 returns 0.
- Fill ctx0 and ctx1 with nonzero values, pulse clr_req_i with clr_ctx_i=1 -> clr_busy_o high for 9 cycles (8 CLEAR + DONE) at defaults, clr_done_o pulses once; then ctx1 reads all 0 and ctx0 is unchanged. A ctx1 write during busy is dropped; a ctx0 write during busy lands.
- Assert rst_ni low during the 3rd CLEAR cycle -> clr_busy_o=0 immediately, all words read 0, no clr_done_o pulse.
